// File: rtl/pc_sequencer.sv
// pc_sequencer: 13-bit program counter with flag register,
// conditional branch resolution and a small return-address stack.
module pc_sequencer #(
  parameter int          STACK_DEPTH = 4,
  parameter logic [12:0] RESET_PC    = 13'h0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   status,
  input  logic                         flag_we,
  input  logic                         pc_en,
  input  logic [2:0]                   op,
  input  logic [12:0]                  target,
  input  logic                         err_clr,
  output logic [12:0]                  pc,
  output logic                         carry_flag,
  output logic                         zero_flag,
  output logic                         neg_flag,
  output logic                         taken,
  output logic [$clog2(STACK_DEPTH):0] depth,
  output logic                         stack_ovf,
  output logic                         stack_unf
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  localparam logic [2:0] OP_NEXT = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_JNZ  = 3'b011;
  localparam logic [2:0] OP_JC   = 3'b100;
  localparam logic [2:0] OP_JNC  = 3'b101;
  localparam logic [2:0] OP_CALL = 3'b110;
  localparam logic [2:0] OP_RET  = 3'b111;

  logic [12:0]   r_pc;
  logic          r_c;
  logic          r_z;
  logic          r_n;
  logic          r_taken;
  logic [DW-1:0] r_depth;
  logic          r_ovf;
  logic          r_unf;
  logic [12:0]   r_stack [STACK_DEPTH];

  logic [12:0]   w_pc_inc;
  logic          w_full;
  logic          w_empty;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic [12:0]   w_top;

  logic [12:0]   w_pc_nxt;
  logic          w_taken_nxt;
  logic [DW-1:0] w_depth_nxt;
  logic          w_push;
  logic          w_ovf_set;
  logic          w_unf_set;

  assign w_pc_inc = r_pc + 13'd1;
  assign w_full   = (r_depth == FULL);
  assign w_empty  = (r_depth == '0);
  assign w_wr_idx = r_depth[AW-1:0];
  assign w_rd_idx = AW'(r_depth - DW'(1));
  assign w_top    = r_stack[w_rd_idx];

  // Decode the sequencing op into next PC, stack action and error events.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_taken_nxt = r_taken;
    w_depth_nxt = r_depth;
    w_push      = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    if (pc_en) begin
      w_pc_nxt    = w_pc_inc;
      w_taken_nxt = 1'b0;
      unique case (op)
        OP_NEXT: begin
          w_pc_nxt = w_pc_inc;
        end
        OP_JMP: begin
          w_pc_nxt    = target;
          w_taken_nxt = 1'b1;
        end
        OP_JZ: begin
          if (r_z) begin
            w_pc_nxt    = target;
            w_taken_nxt = 1'b1;
          end
        end
        OP_JNZ: begin
          if (!r_z) begin
            w_pc_nxt    = target;
            w_taken_nxt = 1'b1;
          end
        end
        OP_JC: begin
          if (r_c) begin
            w_pc_nxt    = target;
            w_taken_nxt = 1'b1;
          end
        end
        OP_JNC: begin
          if (!r_c) begin
            w_pc_nxt    = target;
            w_taken_nxt = 1'b1;
          end
        end
        OP_CALL: begin
          if (w_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_push      = 1'b1;
            w_depth_nxt = r_depth + DW'(1);
            w_pc_nxt    = target;
            w_taken_nxt = 1'b1;
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_unf_set = 1'b1;
          end else begin
            w_depth_nxt = r_depth - DW'(1);
            w_pc_nxt    = w_top;
            w_taken_nxt = 1'b1;
          end
        end
        default: begin
          w_pc_nxt = w_pc_inc;
        end
      endcase
    end
  end

  // PC, redirect indication and stack occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_taken <= 1'b0;
      r_depth <= '0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_taken <= w_taken_nxt;
      r_depth <= w_depth_nxt;
    end
  end

  // Flag register; its C bit feeds the ALU carry-in directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c <= 1'b0;
      r_z <= 1'b0;
      r_n <= 1'b0;
    end else if (flag_we) begin
      {r_c, r_z, r_n} <= status;
    end
  end

  // Sticky stack errors; a new error in the clearing cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~err_clr);
      r_unf <= w_unf_set | (r_unf & ~err_clr);
    end
  end

  // Return-address storage; contents after reset are irrelevant.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_wr_idx] <= w_pc_inc;
    end
  end

  assign pc         = r_pc;
  assign carry_flag = r_c;
  assign zero_flag  = r_z;
  assign neg_flag   = r_n;
  assign taken      = r_taken;
  assign depth      = r_depth;
  assign stack_ovf  = r_ovf;
  assign stack_unf  = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plan steps followed by random ops,
// compared against a queue-based behavioural model.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic [2:0]  status;
  logic        flag_we;
  logic        pc_en;
  logic [2:0]  op;
  logic [12:0] target;
  logic        err_clr;
  logic [12:0] pc;
  logic        carry_flag;
  logic        zero_flag;
  logic        neg_flag;
  logic        taken;
  logic [2:0]  depth;
  logic        stack_ovf;
  logic        stack_unf;

  int checks = 0;
  int errors = 0;

  logic [12:0] m_pc;
  logic        m_c, m_z, m_n, m_tk, m_ovf, m_unf;
  logic [12:0] m_stk [$];

  pc_sequencer #(.STACK_DEPTH(4), .RESET_PC(13'h0000)) dut (
    .clk(clk), .rst(rst), .status(status), .flag_we(flag_we),
    .pc_en(pc_en), .op(op), .target(target), .err_clr(err_clr),
    .pc(pc), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .neg_flag(neg_flag), .taken(taken), .depth(depth),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [12:0] got,
                     input logic [12:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".c"}, 13'(carry_flag), 13'(m_c));
    chk({tag, ".z"}, 13'(zero_flag), 13'(m_z));
    chk({tag, ".n"}, 13'(neg_flag), 13'(m_n));
    chk({tag, ".taken"}, 13'(taken), 13'(m_tk));
    chk({tag, ".depth"}, 13'(depth), 13'(m_stk.size()));
    chk({tag, ".ovf"}, 13'(stack_ovf), 13'(m_ovf));
    chk({tag, ".unf"}, 13'(stack_unf), 13'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = 13'h0000;
    {m_c, m_z, m_n} = 3'b000;
    m_tk = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_edge();
    logic [12:0] inc;
    logic        go;
    inc = m_pc + 13'd1;
    if (err_clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (pc_en) begin
      go = 1'b0;
      case (op)
        3'd1: go = 1'b1;
        3'd2: go = m_z;
        3'd3: go = !m_z;
        3'd4: go = m_c;
        3'd5: go = !m_c;
        default: go = 1'b0;
      endcase
      if (op == 3'd6) begin
        if (m_stk.size() < 4) begin
          m_stk.push_back(inc);
          go = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (op == 3'd7) begin
        if (m_stk.size() > 0) begin
          inc = m_stk.pop_back();
          m_pc = inc;
          m_tk = 1'b1;
        end else begin
          m_pc = inc;
          m_tk = 1'b0;
          m_unf = 1'b1;
        end
      end else begin
        m_pc = go ? target : inc;
        m_tk = go;
      end
    end
    if (flag_we) {m_c, m_z, m_n} = status;
  endtask

  task automatic step(input string tag, input logic en,
                      input logic [2:0] o, input logic [12:0] t,
                      input logic fwe, input logic [2:0] st,
                      input logic clr);
    pc_en = en;
    op = o;
    target = t;
    flag_we = fwe;
    status = st;
    err_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    status = 3'b000;
    flag_we = 1'b0;
    pc_en = 1'b0;
    op = 3'd0;
    target = 13'h0000;
    err_clr = 1'b0;
    model_reset();
    #12;
    do_reset();
    check_all("reset");
    chk("reset.pc_const", pc, 13'h0000);

    step("next1", 1, 3'd0, 13'h0, 0, 3'b0, 0);
    step("next2", 1, 3'd0, 13'h0, 0, 3'b0, 0);
    step("next3", 1, 3'd0, 13'h0, 0, 3'b0, 0);
    chk("next3.pc_const", pc, 13'h0003);

    step("jz_old", 1, 3'd2, 13'h0100, 1, 3'b010, 0);
    chk("jz_old.pc_const", pc, 13'h0004);
    step("jz_new", 1, 3'd2, 13'h0100, 0, 3'b0, 0);
    chk("jz_new.pc_const", pc, 13'h0100);
    step("jnz", 1, 3'd3, 13'h0800, 0, 3'b0, 0);
    chk("jnz.pc_const", pc, 13'h0101);

    step("jmp_top", 1, 3'd1, 13'h1FFF, 0, 3'b0, 0);
    step("wrap", 1, 3'd0, 13'h0, 0, 3'b0, 0);
    chk("wrap.pc_const", pc, 13'h0000);
    step("jmp_top2", 1, 3'd1, 13'h1FFF, 0, 3'b0, 0);
    step("call_top", 1, 3'd6, 13'h0010, 0, 3'b0, 0);
    chk("call_top.depth_const", 13'(depth), 13'd1);
    step("ret_wrap", 1, 3'd7, 13'h0, 0, 3'b0, 0);
    chk("ret_wrap.pc_const", pc, 13'h0000);

    step("jmp5", 1, 3'd1, 13'h0005, 0, 3'b0, 0);
    for (int i = 1; i <= 4; i++)
      step("call_fill", 1, 3'd6, 13'(i * 256), 0, 3'b0, 0);
    chk("fill.depth_const", 13'(depth), 13'd4);
    step("call_ovf", 1, 3'd6, 13'h0500, 0, 3'b0, 0);
    chk("call_ovf.pc_const", pc, 13'h0401);
    chk("call_ovf.ovf_const", 13'(stack_ovf), 13'd1);
    step("ret1", 1, 3'd7, 13'h0, 0, 3'b0, 0);
    chk("ret1.pc_const", pc, 13'h0301);
    step("ret2", 1, 3'd7, 13'h0, 0, 3'b0, 0);
    step("ret3", 1, 3'd7, 13'h0, 0, 3'b0, 0);
    step("ret4", 1, 3'd7, 13'h0, 0, 3'b0, 0);
    chk("ret4.pc_const", pc, 13'h0006);

    step("jmp20", 1, 3'd1, 13'h0020, 0, 3'b0, 0);
    step("ret_unf", 1, 3'd7, 13'h0, 0, 3'b0, 0);
    chk("ret_unf.pc_const", pc, 13'h0021);
    step("clr_and_unf", 1, 3'd7, 13'h0, 0, 3'b0, 1);
    chk("clr_and_unf.unf_const", 13'(stack_unf), 13'd1);
    step("clr_only", 0, 3'd0, 13'h0, 0, 3'b0, 1);
    chk("clr_only.unf_const", 13'(stack_unf), 13'd0);

    step("set_c", 1, 3'd0, 13'h0, 1, 3'b100, 0);
    chk("set_c.c_const", 13'(carry_flag), 13'd1);
    step("hold", 0, 3'd1, 13'h0ABC, 0, 3'b0, 0);
    step("call_a", 1, 3'd6, 13'h0040, 0, 3'b0, 0);
    step("call_b", 1, 3'd6, 13'h0080, 0, 3'b0, 0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom;
      if (r[7:0] == 8'd0) begin
        do_reset();
        check_all("rnd_rst");
      end else begin
        step("rnd", r[10:8] != 3'd0, r[13:11], 13'($urandom),
             r[14], r[17:15], r[20:18] == 3'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and flag-consumer block for the 8-bit datapath. It latches the ALU status triple {C, Z, N} into a flag register and resolves conditional branches from those flags.
- It sequences a 13-bit PC through increment, jump, call and return.
- It holds a small return-address stack.
- Its registered carry flag feeds back to the ALU carry-in for multi-byte add chains.

Parameters:
- STACK_DEPTH, 4, return-address stack entries (power of two, 2..16).
- RESET_PC, 13'h0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- status  input  3  ALU status {C, Z, N}
- flag_we  input  1  capture status into flag register this cycle
- pc_en  input  1  PC/stack update enable; when low, PC and stack hold
- op  input  3  sequencing op: 000 NEXT, 001 JMP, 010 JZ, 011 JNZ, 100 JC, 101 JNC, 110 CALL, 111 RET
- target  input  13  branch/call destination
- err_clr  input  1  clear sticky error bits
- pc  output  13  current program counter (registered)
- carry_flag  output  1  registered C; drives ALU carry-in
- zero_flag  output  1  registered Z
- neg_flag  output  1  registered N
- taken  output  1  registered; 1 if the last enabled op redirected the PC (JMP, taken Jcc, accepted CALL, accepted RET)
- depth  output  $clog2(STACK_DEPTH)+1  current stack occupancy
- stack_ovf  output  1  sticky: CALL attempted while full
- stack_unf  output  1  sticky: RET attempted while empty

Behaviour:
- Reset (async, active-high): pc=RESET_PC; all flags 0; taken 0; depth 0; stack_ovf 0; stack_unf 0. Stack contents are don't-care. Reset asserted mid-operation overrides everything immediately.
- Flag register: on a clk edge with flag_we=1, {carry_flag, zero_flag, neg_flag} <= status. Otherwise flags hold. flag_we is independent of pc_en.
- Branch conditions use the flag register value before the edge. If flag_we and a Jcc occur in the same cycle, the old flags decide; the new flags apply from the next cycle.
- pc_en=0: pc, stack, depth and taken hold. Errors are not set. err_clr still acts.
- pc_en=1, per op (pc+1 is modulo 2^13, so 13'h1FFF+1 = 13'h0000):
  - NEXT: pc <= pc+1; taken <= 0.
  - JMP: pc <= target; taken <= 1.
  - JZ / JNZ: if zero_flag is 1 / 0, pc <= target and taken <= 1; else pc <= pc+1 and taken <= 0.
  - JC / JNC: same rule, using carry_flag.
  - CALL, depth<STACK_DEPTH: push pc+1; depth+1; pc <= target; taken <= 1.
  - CALL, depth==STACK_DEPTH: no push; pc <= pc+1; taken <= 0; stack_ovf <= 1.
  - RET, depth>0: pop; pc <= popped value; depth-1; taken <= 1.
  - RET, depth==0: pc <= pc+1; taken <= 0; stack_unf <= 1.
- Stack is LIFO, single-cycle push or pop; no push and pop in the same cycle. Stack contents are not visible externally.
- err_clr=1 clears stack_ovf and stack_unf at the edge. If a new error occurs in the same cycle, the new error wins (bit ends 1).
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Reset -> pc=0, flags=0, depth=0, errors=0. Then 3 cycles of NEXT with pc_en=1 -> pc=1,2,3; taken=0.
2. flag_we=1 with status=3'b010 and op=JZ, target=0x0100, in the same cycle -> old Z=0, so pc=pc+1, taken=0. Next cycle JZ, target=0x0100 -> pc=0x0100, taken=1. Then JNZ -> pc=0x0101.
3. pc=0x1FFF, NEXT -> pc=0x0000. pc=0x1FFF, CALL target=0x0010 -> pc=0x0010, depth=1. RET -> pc=0x0000, depth=0.
4. STACK_DEPTH=4: CALLs from pc=0x0005 to 0x0100, 0x0200, 0x0300, 0x0400 -> depth=4. Fifth CALL at pc=0x0400 -> pc=0x0401, taken=0, stack_ovf=1, depth=4. Four RETs -> pc=0x0301, 0x0201, 0x0101, 0x0006; depth=0.
5. RET with depth=0 at pc=0x0020 -> pc=0x0021, stack_unf=1. err_clr=1 together with another RET on empty stack -> stack_unf stays 1. err_clr alone -> stack_unf=0.
6. flag_we=1, status=3'b100 -> carry_flag=1 next cycle. pc_en=0 with JMP target=0x0ABC -> pc unchanged. Assert rst mid-sequence with depth=2 -> pc=RESET_PC, depth=0, carry_flag=0 immediately, without waiting for a clk edge.
